// File: rtl/decoder_3_8_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoder.
// It drives the decoder en/i inputs and holds a grant until the grantee
// releases it or the grant reaches MAX_HOLD cycles. Between grants it holds
// dec_en low for GAP_CYCLES cycles, so the chip-selects break before make.
module decoder_3_8_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       dec_en,
  output logic [2:0] dec_sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_n;
  logic [2:0]       last, last_n, winner;
  logic [CNT_W-1:0] hold_cnt, hold_n, gap_cnt, gap_n;
  logic             en_n, busy_n, to_n;
  logic [2:0]       sel_n;
  logic [7:0]       gnt_n;
  logic             any_req, hold_max, gap_last, rel;

  assign any_req  = |req;
  assign hold_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign gap_last = (gap_cnt == CNT_W'(GAP_CYCLES - 1));
  assign rel      = !req[dec_sel] || hold_max;

  // Winner search: the first request found scanning last+1 .. last+8 (mod 8).
  always_comb begin
    logic [2:0] idx;
    logic       found;
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State register and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dec_en   <= 1'b0;
      dec_sel  <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= 3'd7;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      dec_en   <= en_n;
      dec_sel  <= sel_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      timeout  <= to_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
    end
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (any_req) state_n = GRANT;
      GRANT: if (rel) state_n = GAP;
      GAP:   if (gap_last) state_n = any_req ? GRANT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and priority pointer.
  always_comb begin
    en_n   = dec_en;
    sel_n  = dec_sel;
    gnt_n  = gnt;
    to_n   = 1'b0;
    last_n = last;
    hold_n = hold_cnt;
    gap_n  = gap_cnt;
    unique case (state)
      IDLE, GAP: begin
        if (state == GAP && !gap_last) begin
          gap_n = gap_cnt + CNT_W'(1);
        end else if (any_req) begin
          en_n   = 1'b1;
          sel_n  = winner;
          gnt_n  = 8'b0000_0001 << winner;
          last_n = winner;
          hold_n = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          en_n  = 1'b0;
          gnt_n = '0;
          gap_n = '0;
          // A grantee that drops req on the final cycle is a normal release.
          to_n  = req[dec_sel];
        end else begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        en_n  = 1'b0;
        gnt_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_decoder_3_8_rr_arbiter.sv
// Directed scoreboard bench for decoder_3_8_rr_arbiter: two instances
// (MAX_HOLD=16 and MAX_HOLD=4) share clk/rst/req; each step queues the
// expected outputs after the next rising edge for one of the two instances.
module tb_decoder_3_8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic       en_a, bz_a, to_a, en_b, bz_b, to_b;
  logic [2:0] sel_a, sel_b;
  logic [7:0] gnt_a, gnt_b;

  decoder_3_8_rr_arbiter #(.MAX_HOLD(16), .GAP_CYCLES(1), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .req(req), .dec_en(en_a), .dec_sel(sel_a),
    .gnt(gnt_a), .busy(bz_a), .timeout(to_a)
  );

  decoder_3_8_rr_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .req(req), .dec_en(en_b), .dec_sel(sel_b),
    .gnt(gnt_b), .busy(bz_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    bit          b;
    int unsigned id;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int unsigned step_id = 0;
  logic [13:0] obs;
  logic [7:0]  inv_a, inv_b;

  // Expected output word: {gnt, dec_en, dec_sel, busy, timeout}.
  function automatic logic [13:0] pk(input logic [7:0] g, input logic en,
                                     input logic [2:0] s, input logic bz,
                                     input logic to);
    return {g, en, s, bz, to};
  endfunction

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] g,
                      input logic en, input logic [2:0] s, input logic bz,
                      input logic to, input bit b);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    e.v  = pk(g, en, s, bz, to);
    e.b  = b;
    e.id = step_id;
    step_id++;
    q.push_back(e);
  endtask

  task automatic grant(input logic [7:0] rq, input logic [2:0] s, input bit b);
    step(1'b0, rq, 8'b0000_0001 << s, 1'b1, s, 1'b1, 1'b0, b);
  endtask

  task automatic gap(input logic [7:0] rq, input logic [2:0] s, input logic to, input bit b);
    step(1'b0, rq, 8'h00, 1'b0, s, 1'b1, to, b);
  endtask

  task automatic idle(input logic [7:0] rq, input logic [2:0] s, input bit b);
    step(1'b0, rq, 8'h00, 1'b0, s, 1'b0, 1'b0, b);
  endtask

  task automatic do_reset(input logic [7:0] rq);
    step(1'b1, rq, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard: pop the expectation for the edge that just happened.
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      cur = q.pop_front();
      obs = cur.b ? {gnt_b, en_b, sel_b, bz_b, to_b}
                  : {gnt_a, en_a, sel_a, bz_a, to_a};
      checks++;
      assert (obs === cur.v) else begin
        errors++;
        $error("FAIL step%0d dut_%s {gnt,en,sel,busy,to} observed %h expected %h",
               cur.id, cur.b ? "b" : "a", obs, cur.v);
      end
      inv_a = en_a ? (8'b0000_0001 << sel_a) : 8'h00;
      inv_b = en_b ? (8'b0000_0001 << sel_b) : 8'h00;
      checks++;
      assert (gnt_a === inv_a) else begin
        errors++;
        $error("FAIL step%0d onehot_a gnt observed %h expected %h", cur.id, gnt_a, inv_a);
      end
      checks++;
      assert (gnt_b === inv_b) else begin
        errors++;
        $error("FAIL step%0d onehot_b gnt observed %h expected %h", cur.id, gnt_b, inv_b);
      end
    end
  end

  initial begin
    logic [7:0] m;
    logic [2:0] s;
    rst = 1'b1;
    req = 8'h00;

    // 1: reset, then quiet
    do_reset(8'h00);
    do_reset(8'h00);
    for (int i = 0; i < 10; i++) idle(8'h00, 3'd0, 1'b0);

    // 2: single short request from requester 0
    for (int i = 0; i < 3; i++) grant(8'h01, 3'd0, 1'b0);
    gap(8'h00, 3'd0, 1'b0, 1'b0);
    idle(8'h00, 3'd0, 1'b0);
    idle(8'h00, 3'd0, 1'b0);

    // 3: all requesting, each grantee releases after 2 cycles
    do_reset(8'h00);
    grant(8'hFF, 3'd0, 1'b0);
    for (int g = 0; g < 8; g++) begin
      s = 3'(g);
      m = 8'hFF & ~(8'b0000_0001 << s);
      grant(8'hFF, s, 1'b0);
      gap(m, s, 1'b0, 1'b0);
      grant(8'hFF, s + 3'd1, 1'b0);
    end
    grant(8'hFF, 3'd0, 1'b0);
    gap(8'hFE, 3'd0, 1'b0, 1'b0);
    idle(8'h00, 3'd0, 1'b0);

    // 4: sole requester 3 held past MAX_HOLD=16
    for (int i = 0; i < 16; i++) grant(8'h08, 3'd3, 1'b0);
    gap(8'h08, 3'd3, 1'b1, 1'b0);
    grant(8'h08, 3'd3, 1'b0);
    gap(8'h00, 3'd3, 1'b0, 1'b0);
    idle(8'h00, 3'd3, 1'b0);

    // 5: requesters 0 and 3 held, MAX_HOLD=4 instance
    do_reset(8'h00);
    for (int k = 0; k < 4; k++) begin
      s = (k % 2 == 1) ? 3'd3 : 3'd0;
      for (int i = 0; i < 4; i++) grant(8'h09, s, 1'b1);
      gap(8'h09, s, 1'b1, 1'b1);
    end
    idle(8'h00, 3'd3, 1'b1);

    // 6: reset during the second cycle of a grant to 5
    do_reset(8'h00);
    grant(8'h20, 3'd5, 1'b0);
    step(1'b1, 8'h20, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    grant(8'h20, 3'd5, 1'b0);
    gap(8'h00, 3'd5, 1'b0, 1'b0);
    idle(8'h00, 3'd5, 1'b0);

    @(posedge clk);
    #4;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending observed %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
